// File: rtl/lcd_pkg.sv
// Shared LCD definitions: word layout, serialiser FSM encoding,
// default timing and the command opcodes used across LCD blocks.
package lcd_pkg;

  localparam int LCD_WORD_W       = 9;
  localparam int LCD_DC_BIT       = 8;
  localparam int LCD_DIV_HALF_DEF = 2;
  localparam int LCD_SETTLE_DEF   = 2;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_SETTLE = 5'b00010,
    ST_SHIFT  = 5'b00100,
    ST_HOLD   = 5'b01000,
    ST_DONE   = 5'b10000
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_SLPOUT = 8'h11;
  localparam logic [7:0] LCD_CMD_DISPON = 8'h29;
  localparam logic [7:0] LCD_CMD_CASET  = 8'h2A;
  localparam logic [7:0] LCD_CMD_RASET  = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] LCD_CMD_MADCTL = 8'h36;
  localparam logic [7:0] LCD_CMD_COLMOD = 8'h3A;

  function automatic logic [LCD_WORD_W-1:0] lcd_word(
    input logic       dc,
    input logic [7:0] payload
  );
    return {dc, payload};
  endfunction

endpackage

// File: rtl/lcd_spi_tick.sv
// SCK half-period tick: one-cycle pulse every DIV_HALF cycles
// while enabled; the count restarts whenever enable drops.
module lcd_spi_tick
  import lcd_pkg::*;
#(
  parameter int DIV_HALF = LCD_DIV_HALF_DEF
) (
  input  logic sys_clk_50MHz,
  input  logic sys_rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV_HALF - 1);

  logic [7:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/lcd_spi_write.sv
// 9-bit D/C + byte serialiser, SPI mode 0, MSB first, registered
// outputs; pulses wr_done as CS rises after each complete byte.
module lcd_spi_write
  import lcd_pkg::*;
#(
  parameter int DIV_HALF   = LCD_DIV_HALF_DEF,
  parameter int SETTLE_CYC = LCD_SETTLE_DEF
) (
  input  logic                  sys_clk_50MHz,
  input  logic                  sys_rst_n,
  input  logic                  en_write,
  input  logic [LCD_WORD_W-1:0] data_in,
  output logic                  wr_done,
  output logic                  lcd_cs,
  output logic                  lcd_dc,
  output logic                  lcd_sck,
  output logic                  lcd_mosi
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  lcd_state_e state_q, state_d;

  logic [3:0] set_q, set_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       cs_d, sck_d, mosi_d;
  logic       dc_d, done_d;
  logic       tick, shifting, latch;

  assign shifting = (state_q == ST_SHIFT)
                 || (state_q == ST_HOLD);
  assign latch = (state_q == ST_SETTLE)
              && en_write
              && (set_q == SETTLE_LAST);

  lcd_spi_tick #(
    .DIV_HALF(DIV_HALF)
  ) u_tick (
    .sys_clk_50MHz(sys_clk_50MHz),
    .sys_rst_n    (sys_rst_n),
    .enable       (shifting),
    .tick         (tick)
  );

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en_write) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en_write) state_d = ST_IDLE;
        else if (latch) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick && lcd_sck && (bit_q == 3'd7))
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = en_write ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SCK phase only moves on a tick; MOSI advances on the falling edge
  always_comb begin
    set_d  = '0;
    bit_d  = bit_q;
    sh_d   = sh_q;
    sck_d  = lcd_sck;
    mosi_d = lcd_mosi;
    dc_d   = lcd_dc;
    cs_d   = !((state_d == ST_SHIFT)
            || (state_d == ST_HOLD));
    done_d = (state_d == ST_DONE);
    unique case (state_q)
      ST_SETTLE: begin
        if (latch) begin
          sh_d   = data_in[7:0];
          mosi_d = data_in[7];
          dc_d   = data_in[LCD_DC_BIT];
          bit_d  = '0;
          sck_d  = 1'b0;
        end else if (en_write) begin
          set_d = set_q + 4'd1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!lcd_sck) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d  = bit_q + 3'd1;
              sh_d   = {sh_q[6:0], 1'b0};
              mosi_d = sh_q[6];
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) mosi_d = 1'b0;
      end
      ST_IDLE, ST_DONE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      set_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      lcd_cs   <= 1'b1;
      lcd_sck  <= 1'b0;
      lcd_mosi <= 1'b0;
      lcd_dc   <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      set_q    <= set_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      lcd_cs   <= cs_d;
      lcd_sck  <= sck_d;
      lcd_mosi <= mosi_d;
      lcd_dc   <= dc_d;
      wr_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: upstream stimulus feeds a scoreboard, an
// SPI bus monitor decodes each CS window and checks it on wr_done.
module tb_lcd_spi_write;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst0, rst1, en0, en1;
  logic [8:0] d0, d1;
  logic       done0, cs0, dc0, sck0, mosi0;
  logic       done1, cs1, dc1, sck1, mosi1;

  lcd_spi_write #(.DIV_HALF(2), .SETTLE_CYC(2)) dut (
    .sys_clk_50MHz(clk), .sys_rst_n(rst0),
    .en_write(en0), .data_in(d0), .wr_done(done0),
    .lcd_cs(cs0), .lcd_dc(dc0), .lcd_sck(sck0),
    .lcd_mosi(mosi0)
  );

  lcd_spi_write #(.DIV_HALF(1), .SETTLE_CYC(2)) dut1 (
    .sys_clk_50MHz(clk), .sys_rst_n(rst1),
    .en_write(en1), .data_in(d1), .wr_done(done1),
    .lcd_cs(cs1), .lcd_dc(dc1), .lcd_sck(sck1),
    .lcd_mosi(mosi1)
  );

  typedef struct {
    logic [8:0] word;
    int         gap;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [8:0] wq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         use1 = 1'b0;

  logic cs_m, done_m;
  assign cs_m   = use1 ? cs1 : cs0;
  assign done_m = use1 ? done1 : done0;

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, req, $time);
    end
  endtask

  // bus monitor state, indexed by instance
  int         m_l[2], m_rises[2], m_last_done[2];
  int         m_mchg[2], m_rise[2];
  logic [7:0] m_bits[2];
  logic       m_dc[2], m_in[2], m_pcs[2], m_psck[2], m_pmosi[2];

  task automatic mon(input int id, input logic rst,
                     input logic cs, input logic sck,
                     input logic mosi, input logic dc,
                     input logic done, input int dh);
    exp_t e;
    int   qs;
    if (!rst) begin
      m_in[id] = 1'b0;
      m_pcs[id] = 1'b1;
      m_psck[id] = 1'b0;
      m_pmosi[id] = 1'b0;
      return;
    end
    if (!cs && m_pcs[id]) begin
      m_in[id] = 1'b1;
      m_l[id] = cyc;
      m_rises[id] = 0;
      m_bits[id] = '0;
      m_dc[id] = dc;
      m_mchg[id] = cyc;
      m_rise[id] = -1000;
    end
    if (m_in[id] && !cs) begin
      if (dc != m_dc[id]) chk("dc_stable", int'(dc), int'(m_dc[id]));
      if (sck && !m_psck[id]) begin
        m_rises[id]++;
        m_bits[id] = {m_bits[id][6:0], mosi};
        chk("rise_time", cyc - m_l[id], dh * (2 * m_rises[id] - 1));
        chk("mosi_setup", int'(cyc - m_mchg[id] >= dh), 1);
        m_rise[id] = cyc;
      end
      if (mosi != m_pmosi[id] && cyc != m_l[id]) begin
        chk("mosi_on_fall", int'(!sck && m_psck[id]), 1);
        chk("mosi_hold", int'(cyc - m_rise[id] >= dh), 1);
        m_mchg[id] = cyc;
      end
    end
    if (done) begin
      chk("done_with_cs_rise", int'(cs && !m_pcs[id]), 1);
      chk("done_time", cyc - m_l[id], 17 * dh);
      chk("rise_count", m_rises[id], 8);
      qs = (id == 0) ? q0.size() : q1.size();
      chk("byte_expected", int'(qs > 0), 1);
      if (qs > 0) begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("byte", int'(m_bits[id]), int'(e.word[7:0]));
        chk("dc", int'(m_dc[id]), int'(e.word[8]));
        if (e.gap != 0) chk("byte_gap", cyc - m_last_done[id], e.gap);
      end
      m_last_done[id] = cyc;
      m_in[id] = 1'b0;
    end
    m_pcs[id] = cs;
    m_psck[id] = sck;
    m_pmosi[id] = mosi;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, rst0, cs0, sck0, mosi0, dc0, done0, 2);
    mon(1, rst1, cs1, sck1, mosi1, dc1, done1, 1);
  end

  task automatic set_en(input bit v);
    if (use1) en1 = v;
    else en0 = v;
  endtask

  task automatic set_data(input logic [8:0] v);
    if (use1) d1 = v;
    else d0 = v;
  endtask

  task automatic wait_done(output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < 400 && !ok) begin
      @(negedge clk);
      k++;
      ok = done_m;
    end
    chk("wr_done_seen", int'(done_m), 1);
  endtask

  // upstream model: 000 for one cycle after en rises, next word 2 cycles after each wr_done
  task automatic send(input int drop_at);
    int   dh  = use1 ? 1 : 2;
    int   gap = 17 * dh + 1 + 2;
    int   n   = wq.size();
    bit   ok  = 1'b1;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.word = wq[i];
      e.gap  = (i == 0) ? 0 : gap;
      if (use1) q1.push_back(e);
      else q0.push_back(e);
    end
    @(negedge clk);
    set_en(1'b1);
    set_data(9'h000);
    @(negedge clk);
    chk("latency_c1_cs", int'(cs_m), 1);
    set_data(wq[0]);
    @(negedge clk);
    chk("latency_c2_cs", int'(cs_m), 1);
    @(negedge clk);
    chk("latency_c3_cs", int'(cs_m), 0);
    if (drop_at >= 0) begin
      repeat (drop_at) @(negedge clk);
      set_en(1'b0);
      set_data(9'($urandom));
    end
    for (int i = 0; i < n && ok; i++) begin
      wait_done(ok);
      if (ok && i < n - 1) begin
        repeat (2) @(negedge clk);
        set_data(wq[i + 1]);
      end
    end
    set_en(1'b0);
    repeat (60) @(negedge clk);
    chk("idle_cs", int'(cs_m), 1);
  endtask

  task automatic reset_mid_byte(input logic [8:0] w);
    int   r = 0;
    logic ps = 1'b0;
    bit   ok;
    exp_t e;
    use1 = 1'b0;
    @(negedge clk);
    d0 = w;
    en0 = 1'b1;
    for (int k = 0; k < 400 && r < 4; k++) begin
      @(posedge clk);
      #1;
      if (sck0 && !ps) r++;
      ps = sck0;
    end
    rst0 = 1'b0;
    #1;
    chk("rst_at_rise4", r, 4);
    chk("rst_cs", int'(cs0), 1);
    chk("rst_sck", int'(sck0), 0);
    chk("rst_mosi", int'(mosi0), 0);
    chk("rst_done", int'(done0), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", int'(done0), 0);
    end
    e.word = w;
    e.gap = 0;
    q0.push_back(e);
    rst0 = 1'b1;
    wait_done(ok);
    en0 = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_idle_cs", int'(cs0), 1);
  endtask

  task automatic random_words(input int count, input int maxdrop);
    int n;
    for (int t = 0; t < count; t++) begin
      n = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(9'($urandom));
      if (n == 1 && $urandom_range(0, 1) == 1)
        send($urandom_range(0, maxdrop));
      else
        send(-1);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    en0 = 1'b0;  en1 = 1'b0;
    d0 = '0;     d1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_cs", int'(cs0), 1);
    chk("reset_sck", int'(sck0), 0);
    chk("reset_mosi", int'(mosi0), 0);
    chk("reset_dc", int'(dc0), 0);
    chk("reset_done", int'(done0), 0);
    chk("reset_cs_dh1", int'(cs1), 1);
    chk("reset_done_dh1", int'(done1), 0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(negedge clk);

    use1 = 1'b0;
    wq.delete(); wq.push_back(9'h011); send(-1);
    wq.delete(); wq.push_back(9'h1A5); send(-1);
    wq.delete();
    wq.push_back(9'h036);
    wq.push_back(9'h108);
    wq.push_back(9'h03A);
    send(-1);
    wq.delete(); wq.push_back(9'h0B2); send(5);
    reset_mid_byte(9'h0C3);
    use1 = 1'b0;
    random_words(6, 30);

    use1 = 1'b1;
    wq.delete(); wq.push_back(9'h1FF); send(-1);
    random_words(4, 14);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty_dh2", q0.size(), 0);
    chk("scoreboard_empty_dh1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_spi_write.md
Name: lcd_spi_write

Overview:
- Serialising stage directly downstream of the LCD init/sequencer block.
- Takes 9-bit command/data words (bit 8 = D/C, bits 7:0 = payload) while en_write is high, and shifts each word out MSB-first over 4-wire SPI mode 0 (CS, DC, SCK, MOSI).
- Pulses wr_done once per completed byte; the upstream sequencer advances its word counter on that pulse.

Parameters:
- DIV_HALF, 2, sys_clk cycles per SCK half-period; range 1..255; SCK = 50 MHz / (2*DIV_HALF).
- SETTLE_CYC, 2, cycles data must be stable with en_write high before latching; minimum 2, to cover the upstream counter-then-data register latency.

Ports:
- sys_clk_50MHz  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- en_write  in  1  upstream request; level, held high for a whole burst.
- data_in  in  9  [8] = D/C (1 data, 0 command); [7:0] = byte.
- wr_done  out  1  one-cycle pulse, byte fully shifted.
- lcd_cs  out  1  chip select, active-low.
- lcd_dc  out  1  D/C line.
- lcd_sck  out  1  SPI clock, idle low.
- lcd_mosi  out  1  serial data.

Behaviour:
- All outputs are registered.
- Reset values: lcd_cs=1, lcd_sck=0, lcd_mosi=0, lcd_dc=0, wr_done=0. Internal state goes to IDLE and all counters clear.
- FSM states: IDLE, SETTLE, SHIFT, HOLD, DONE.
- IDLE:
  - Outputs at reset values.
  - en_write=1 -> SETTLE, with settle counter cleared.
- SETTLE:
  - The counter increments each cycle while en_write=1.
  - en_write=0 at any point -> IDLE.
  - When the counter reaches SETTLE_CYC, latch data_in into the shift register and go to SHIFT.
- SHIFT timing (cycle L = first cycle with lcd_cs=0):
  - At L: lcd_dc=latched[8], lcd_mosi=latched[7], lcd_sck=0.
  - Bit k (k=0..7, MSB first): SCK low for DIV_HALF cycles, then high for DIV_HALF cycles.
  - SCK rising edge at L + DIV_HALF + 2*k*DIV_HALF.
  - MOSI changes only together with an SCK falling edge, and never while SCK is high.
  - A 3-bit bit counter; after the high phase of bit 7 (last bit = payload bit 0) -> HOLD.
- HOLD:
  - SCK low, CS still low, for DIV_HALF cycles -> DONE.
- DONE (one cycle):
  - lcd_cs=1 and wr_done=1 in the same cycle, at L + 17*DIV_HALF.
  - Next state is SETTLE if en_write=1, else IDLE.
  - The gap guarantees the next word is sampled only after upstream has updated data_in (upstream updates 2 cycles after wr_done).
- DC: lcd_dc holds its value after DONE until the next latch; it is not forced back to 0.
- en_write deasserted during SHIFT or HOLD: the current byte completes, wr_done still pulses, then IDLE. A byte is never truncated.
- data_in changes after latch are ignored.
- Async reset mid-byte: outputs go to reset values immediately (CS high, SCK low). No wr_done is emitted for the aborted byte.
- Latency with defaults: rising en_write to first CS low = 3 cycles; byte period = 34 cycles (CS low) plus 1 DONE cycle plus SETTLE_CYC cycles, i.e. 37 cycles per byte in a burst.
- Counter width rules:
  - Half-period counter is 8 bits and compares to DIV_HALF-1.
  - Settle counter is 4 bits.
  - Counters saturate-free: they are reset at each state entry.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_WORD_W=9 and LCD_DC_BIT=8.
  - The FSM state encoding (one-hot, 5 bits).
  - Default DIV_HALF.
  - Command opcodes used across LCD blocks (0x11, 0x29, 0x2A, 0x2B, 0x2C, 0x36, 0x3A).
- One sub-module, lcd_spi_tick: half-period tick generator.
  - Inputs: enable, DIV_HALF.
  - Output: a 1-cycle tick every DIV_HALF cycles while enabled; cleared when disabled.
  - The FSM advances SCK phase only on that tick.

Test Plan:
- Command word: data_in=9'h011 with en_write held, defaults.
  - Required: lcd_dc=0 throughout the CS-low window; MOSI sampled on the 8 SCK rises = 0,0,0,1,0,0,0,1.
  - Required: exactly 8 rising edges; wr_done a single pulse at L+34 coincident with lcd_cs rising.
- Data word: data_in=9'h1A5.
  - Required: lcd_dc=1; sampled bits 1,0,1,0,0,1,0,1.
  - Required: MOSI is stable for DIV_HALF cycles before and after every SCK rise.
- Burst handshake using an upstream model that updates data_in 2 cycles after each wr_done and presents 9'h000 for 1 cycle after en_write rises.
  - Sequence: 9'h036, 9'h108, 9'h03A.
  - Required: exactly 3 bytes transmitted with correct values, no leading 9'h000 byte, 3 wr_done pulses 37 cycles apart.
- en_write dropped 5 cycles into SHIFT of 9'h0B2.
  - Required: the full byte still transmits; wr_done pulses; FSM returns to IDLE with CS=1; no further bytes.
- sys_rst_n asserted at the 4th SCK rise.
  - Required: same cycle lcd_cs=1, lcd_sck=0, lcd_mosi=0, no wr_done.
  - Required: after release with en_write=1, a fresh full byte is sent.
- DIV_HALF=1 with word 9'h1FF.
  - Required: SCK period 2 cycles; 8 rises; wr_done at L+17; all sampled bits = 1; dc=1.
